// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray output and wrap pulse, plus an independent Gray->binary converter.
// Latency 1 cycle for all outputs; no backpressure, every input is accepted each cycle.
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  input  logic             cnv_valid_i,
  input  logic [WIDTH-1:0] cnv_gray_i,
  output logic             cnv_valid_o,
  output logic [WIDTH-1:0] cnv_bin_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic             wrap_q;
  logic             cnv_valid_d;
  logic             cnv_valid_q;
  logic [WIDTH-1:0] cnv_bin_d;
  logic [WIDTH-1:0] cnv_bin_q;

  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d  = load_bin;
      gray_d = load_bin ^ (load_bin >> 1);
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + ONE;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = ~|bin_q;
      end
      // Gray is encoded from the next binary value so both registers move on the same edge.
      gray_d = bin_d ^ (bin_d >> 1);
    end
  end

  always_comb begin
    cnv_valid_d = cnv_valid_i;
    cnv_bin_d   = cnv_bin_q;
    if (cnv_valid_i) begin
      cnv_bin_d[WIDTH-1] = cnv_gray_i[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
        cnv_bin_d[i] = cnv_bin_d[i+1] ^ cnv_gray_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      gray_q      <= '0;
      wrap_q      <= 1'b0;
      cnv_valid_q <= 1'b0;
      cnv_bin_q   <= '0;
    end else begin
      bin_q       <= bin_d;
      gray_q      <= gray_d;
      wrap_q      <= wrap_d;
      cnv_valid_q <= cnv_valid_d;
      cnv_bin_q   <= cnv_bin_d;
    end
  end

  assign wrap        = wrap_q;
  assign cnv_valid_o = cnv_valid_q;
  assign cnv_bin_o   = cnv_bin_q;

endmodule
